gelato_fetch_scheduler: RTL
===========================

// Module: gelato_fetch_scheduler
// PURPOSE
// - Consumer end of the split-table -> fetch-scheduler PC-table interface.
// - Each cycle, picks one warp whose split table presents a valid PC and which is not in flight.
// - Issues that warp's PC and split-table entry to the I-fetch stage over a valid/ready handshake.
// - The warp stays blocked until decode re-activates it via activate_valid/activate_warp_num.
// PARAMETERS
// - WARP_NUM         4   number of warps (power of 2)
// - PC_WIDTH         32  program counter width
// - SPLIT_NUM_WIDTH  2   width of split-table entry index
// PORTS
// - clk                    in   1                      clock
// - rst_n                  in   1                      reset, asynchronous, active-low
// - rdy                    in   1                      global enable; all state holds when low
// - pct_valid              in   WARP_NUM               per-warp PC valid from split table
// - pct_pc                 in   WARP_NUM*PC_WIDTH      per-warp current PC
// - pct_split_table_num    in   WARP_NUM*SPLIT_NUM_W   per-warp active split entry
// - pct_activate_valid     in   1                      warp re-activation strobe (registered in split table)
// - pct_activate_warp_num  in   log2(WARP_NUM)         warp to re-activate
// - fetch_valid            out  1                      fetch request valid
// - fetch_ready            in   1                      I-fetch accepts request
// - fetch_pc               out  PC_WIDTH               PC to fetch
// - fetch_warp_num         out  log2(WARP_NUM)         issuing warp
// - fetch_split_table_num  out  SPLIT_NUM_WIDTH        split entry of issuing warp
// - inflight               out  WARP_NUM               per-warp blocked mask (debug/perf)
// - issue_count            out  32                     number of accepted fetches, wraps at 2^32
// BEHAVIOUR
// - Reset values: fetch_valid=0, fetch_pc=0, fetch_warp_num=0, fetch_split_table_num=0,
//   inflight=0, issue_count=0, round-robin pointer=0, state=IDLE.
// - Eligibility: elig[i] = pct_valid[i] & ~inflight[i].
//   Activation takes effect in inflight the next cycle; there is no same-cycle bypass.
// - Arbitration: round-robin starting at ptr. The winner is the first eligible index >= ptr, modulo WARP_NUM.
//   On grant, ptr <= winner+1, wrapping at WARP_NUM.
// - FSM, advancing only when rdy=1:
//   IDLE: if any elig, latch winner's pc/split/warp into output regs, set inflight[winner],
//         fetch_valid<=1, go to ISSUE. Otherwise stay.
//   ISSUE: hold payload stable, even if pct_* changes. On fetch_valid&fetch_ready: issue_count++.
//          If another warp is eligible in the same cycle, latch it back-to-back and stay in ISSUE;
//          otherwise fetch_valid<=0 and go to IDLE.
// - Throughput: 1 request/cycle when fetch_ready is held high. Grant-to-fetch_valid latency is 1 cycle.
// - Activation: pct_activate_valid clears inflight[pct_activate_warp_num] at the clock edge.
//   Activation of a warp not in flight is ignored.
//   A same-cycle grant of warp w and activation of warp w cannot occur, since w is blocked while in flight.
// - A warp whose pct_valid drops while it is in flight stays in flight until activated.
// - rdy=0: no grant, no inflight change, no counter change. An activation arriving while rdy=0 is lost.
//   The producer also gates its activation on rdy.
// - Reset mid-request drops the outstanding request and clears all inflight bits.
// STRUCTURE
// - gelato_types package provides warp_num_t, addr_t, split_table_num_t and `WARP_NUM / `WARP_NUM_WIDTH.
//   No new local typedefs.
// - Sub-module gelato_rr_arbiter (parameter N): inputs req[N] and ptr; outputs grant_valid and
//   grant_idx. Purely combinational.
// - Top level contains the FSM, payload registers, inflight vector and issue_count.
// TESTING
// - Single warp: pct_valid=4'b0001, pc[0]=0x100, ready=1 -> one fetch (warp 0, 0x100), then idle.
//   Activate warp 0 -> second fetch issued 2 cycles after activate.
// - All warps valid, ready=1, activate each warp 1 cycle after its issue -> grant order 0,1,2,3,0,...
//   at 1 request/cycle; issue_count increments each accepted fetch.
// - Backpressure: ready=0 for 5 cycles while pct_pc[1] changes 0x200->0x240 -> fetch_pc stays 0x200
//   with valid held; accepted when ready=1.
// - Activate warp 2 while warp 2 is not in flight -> inflight unchanged; no spurious fetch.
// - rdy=0 for 3 cycles with warps eligible -> no fetch_valid rise, no counter change; resumes with
//   the same ptr.
// - Assert rst_n low while in ISSUE with inflight=4'b0110 -> next cycle fetch_valid=0, inflight=0,
//   issue_count=0.

Source files
------------

// File: rtl/gelato_types_pkg.sv
// Shared types and sizes for the gelato warp front end.
// Provides:
//   WARP_NUM, WARP_NUM_WIDTH, PC_WIDTH, SPLIT_NUM_WIDTH  - structural sizes
//   warp_num_t, addr_t, split_table_num_t               - payload field types
//   fetch_state_e                                       - fetch scheduler FSM states
package gelato_types;

    localparam int unsigned WARP_NUM        = 4;
    localparam int unsigned WARP_NUM_WIDTH  = $clog2(WARP_NUM);
    localparam int unsigned PC_WIDTH        = 32;
    localparam int unsigned SPLIT_NUM_WIDTH = 2;

    typedef logic [WARP_NUM_WIDTH-1:0]  warp_num_t;
    typedef logic [PC_WIDTH-1:0]        addr_t;
    typedef logic [SPLIT_NUM_WIDTH-1:0] split_table_num_t;

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } fetch_state_e;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request at index >= ptr_i, wrapping modulo N.
// Ports:
//   req_i          in   N     request vector
//   ptr_i          in   IdxW  highest-priority index
//   grant_valid_o  out  1     at least one request present
//   grant_idx_o    out  IdxW  winning index (0 when no request)
module gelato_rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic            grant_valid_o,
    output logic [IdxW-1:0] grant_idx_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        grant_idx_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IdxW'((32'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                grant_idx_o = cand;
            end
        end
        grant_valid_o = found;
    end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Fetch scheduler: consumer end of the split-table PC-table interface.
// Each cycle picks one eligible warp (PC valid and not in flight) round-robin, issues its PC and
// split-table entry to I-fetch over valid/ready, and blocks the warp until decode re-activates it.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   rdy_i                       global enable; all state holds when low
//   pct_valid_i                 per-warp PC valid
//   pct_pc_i                    per-warp PC, packed, warp 0 in the LSBs
//   pct_split_table_num_i       per-warp split entry, packed, warp 0 in the LSBs
//   pct_activate_valid_i        re-activation strobe
//   pct_activate_warp_num_i     warp to re-activate
//   fetch_valid_o/fetch_ready_i request handshake to I-fetch
//   fetch_pc_o, fetch_warp_num_o, fetch_split_table_num_o   request payload
//   inflight_o                  per-warp blocked mask
//   issue_count_o               accepted fetch count, wraps
module gelato_fetch_scheduler
    import gelato_types::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                rdy_i,
    input  logic [WARP_NUM-1:0]                 pct_valid_i,
    input  logic [WARP_NUM*PC_WIDTH-1:0]        pct_pc_i,
    input  logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] pct_split_table_num_i,
    input  logic                                pct_activate_valid_i,
    input  warp_num_t                           pct_activate_warp_num_i,
    output logic                                fetch_valid_o,
    input  logic                                fetch_ready_i,
    output addr_t                               fetch_pc_o,
    output warp_num_t                           fetch_warp_num_o,
    output split_table_num_t                    fetch_split_table_num_o,
    output logic [WARP_NUM-1:0]                 inflight_o,
    output logic [31:0]                         issue_count_o
);

    fetch_state_e         state_q;
    logic                 fetch_valid_q;
    addr_t                fetch_pc_q;
    warp_num_t            fetch_warp_num_q;
    split_table_num_t     fetch_split_q;
    logic [WARP_NUM-1:0]  inflight_q;
    logic [31:0]          issue_count_q;
    warp_num_t            ptr_q;

    logic [WARP_NUM-1:0]  elig;
    logic                 grant_valid;
    warp_num_t            grant_idx;
    logic                 take;
    logic                 grant;
    addr_t                sel_pc;
    split_table_num_t     sel_split;
    logic [WARP_NUM-1:0]  act_mask;
    logic [WARP_NUM-1:0]  set_mask;

    // Eligibility uses the registered inflight mask: activation has no same-cycle bypass.
    assign elig = pct_valid_i & ~inflight_q;

    gelato_rr_arbiter #(
        .N (WARP_NUM)
    ) u_arb (
        .req_i         (elig),
        .ptr_i         (ptr_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_comb begin
        // A new request may be latched when the output register is empty or being drained.
        take      = (state_q == StIdle) || fetch_ready_i;
        grant     = take && grant_valid;
        sel_pc    = pct_pc_i[32'(grant_idx) * PC_WIDTH +: PC_WIDTH];
        sel_split = pct_split_table_num_i[32'(grant_idx) * SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
        act_mask  = '0;
        set_mask  = '0;
        if (pct_activate_valid_i) begin
            act_mask[pct_activate_warp_num_i] = 1'b1;
        end
        if (grant) begin
            set_mask[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            fetch_valid_q    <= 1'b0;
            fetch_pc_q       <= '0;
            fetch_warp_num_q <= '0;
            fetch_split_q    <= '0;
            inflight_q       <= '0;
            issue_count_q    <= '0;
            ptr_q            <= '0;
        end else if (rdy_i) begin
            // Clearing a bit that is not set is a no-op, so stray activations vanish here.
            inflight_q <= (inflight_q & ~act_mask) | set_mask;
            if (grant) begin
                fetch_pc_q       <= sel_pc;
                fetch_warp_num_q <= grant_idx;
                fetch_split_q    <= sel_split;
                ptr_q            <= grant_idx + warp_num_t'(1);
            end
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        fetch_valid_q <= 1'b1;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    if (fetch_ready_i) begin
                        issue_count_q <= issue_count_q + 32'd1;
                        if (!grant_valid) begin
                            fetch_valid_q <= 1'b0;
                            state_q       <= StIdle;
                        end
                    end
                end
                default: begin
                    fetch_valid_q <= 1'b0;
                    state_q       <= StIdle;
                end
            endcase
        end
    end

    assign fetch_valid_o           = fetch_valid_q;
    assign fetch_pc_o              = fetch_pc_q;
    assign fetch_warp_num_o        = fetch_warp_num_q;
    assign fetch_split_table_num_o = fetch_split_q;
    assign inflight_o              = inflight_q;
    assign issue_count_o           = issue_count_q;

endmodule
